// File: rtl/regfile_2r1w_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_2r1w_sb_pkg
// Shared constants, types and the 4->16 index decoder for the decode-stage
// register file.
//   DATA_W     register width in bits
//   NUM_REGS   architectural register count
//   REG_IDX_W  register index width
//   R0         index of the hardwired-zero register
//   decode_idx one-hot wordline decoder, shared by the read and write ports
// -----------------------------------------------------------------------------
package regfile_2r1w_sb_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0]    word_t;
    typedef logic [NUM_REGS-1:0]  wordline_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t R0 = '0;

    // Register index to one-hot wordline.
    function automatic wordline_t decode_idx(input reg_idx_t idx);
        wordline_t wl;
        wl      = '0;
        wl[idx] = 1'b1;
        return wl;
    endfunction

endpackage

// File: rtl/regfile_2r1w_sb_word.sv
// -----------------------------------------------------------------------------
// regfile_word
// One DATA_W-bit architectural register with a write enable.
//   clk  core clock
//   rst  synchronous, active-high reset (clears the word)
//   we   write wordline for this register
//   d    write data
//   q    register contents
// -----------------------------------------------------------------------------
module regfile_word
    import regfile_2r1w_sb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  word_t d,
    output word_t q
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// -----------------------------------------------------------------------------
// regfile_2r1w_sb
// 16 x 16-bit register file, two combinational read ports, one write port,
// write-before-read bypass and a per-register busy scoreboard for the hazard
// unit. R0 reads as zero, ignores writes and is never marked busy.
//   clk        core clock
//   rst        synchronous, active-high reset (registers and busy bits)
//   src_reg1/2 read port indices
//   src_data1/2 read port data (bypassed from wr_data on a matching write)
//   wr_en      writeback valid
//   wr_reg     writeback destination index
//   wr_data    writeback data
//   issue_en   issuing instruction will write issue_reg
//   issue_reg  destination index of the issuing instruction
//   src_busy1/2 operand has a pending producer that the bypass cannot cover
//   busy_vec   raw scoreboard bits
// -----------------------------------------------------------------------------
module regfile_2r1w_sb
    import regfile_2r1w_sb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          src_reg1,
    input  logic [3:0]          src_reg2,
    output logic [DATA_W-1:0]   src_data1,
    output logic [DATA_W-1:0]   src_data2,
    input  logic                wr_en,
    input  logic [3:0]          wr_reg,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                issue_en,
    input  logic [3:0]          issue_reg,
    output logic                src_busy1,
    output logic                src_busy2,
    output logic [NUM_REGS-1:0] busy_vec
);

    // Wordlines from the shared index decoder.
    wordline_t rd_wl1, rd_wl2, wr_wl, set_wl;
    logic      wr_ok, issue_ok;

    assign wr_ok    = wr_en && (wr_reg != R0);
    assign issue_ok = issue_en && (issue_reg != R0);

    assign rd_wl1 = decode_idx(src_reg1);
    assign rd_wl2 = decode_idx(src_reg2);
    assign wr_wl  = decode_idx(wr_reg)    & {NUM_REGS{wr_ok}};
    assign set_wl = decode_idx(issue_reg) & {NUM_REGS{issue_ok}};

    // Register storage: R0 is a constant, the rest are real words.
    word_t regs [NUM_REGS];

    assign regs[0] = '0;

    // NOTE: every word carries a reset because software relies on a known
    // all-zero register file after reset; this is not a RAM macro.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
        regfile_word u_word (
            .clk (clk),
            .rst (rst),
            .we  (wr_wl[i]),
            .d   (wr_data),
            .q   (regs[i])
        );
    end

    // Read ports: one-hot AND-OR of wordlines with register contents, then the
    // writeback bypass. wr_ok excludes R0, so a write to R0 never bypasses.
    word_t rd1, rd2;
    logic  byp1, byp2;

    assign byp1 = wr_ok && (wr_reg == src_reg1);
    assign byp2 = wr_ok && (wr_reg == src_reg2);

    always_comb begin
        // NOTE: defaults first so every path assigns rd1/rd2 and no latch
        // is inferred.
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd1 = rd1 | (regs[i] & {DATA_W{rd_wl1[i]}});
            rd2 = rd2 | (regs[i] & {DATA_W{rd_wl2[i]}});
        end
    end

    assign src_data1 = byp1 ? wr_data : rd1;
    assign src_data2 = byp2 ? wr_data : rd2;

    // Scoreboard. Clear is applied before set so that a new producer issued
    // in the writeback cycle of the old one keeps the register busy. Bit 0
    // can never be set because set_wl excludes R0.
    wordline_t busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_wl) | set_wl;
        end
    end

    // A producer writing back this cycle is covered by the bypass.
    assign src_busy1 = busy[src_reg1] & ~(wr_en & (wr_reg == src_reg1));
    assign src_busy2 = busy[src_reg2] & ~(wr_en & (wr_reg == src_reg2));
    assign busy_vec  = busy;

endmodule
